// File: rtl/vga_pkg.sv
// Purpose: shared screen geometry, colour/address widths, pixel record and FSM encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

    localparam int X_SCREEN      = 160;
    localparam int Y_SCREEN      = 120;
    localparam int SCREEN_PIXELS = X_SCREEN * Y_SCREEN;   // 19200
    localparam int COLOUR_W      = 3;
    localparam int ADDR_W        = 15;
    localparam int FIFO_DEPTH_D  = 8;

    typedef logic [COLOUR_W-1:0] colour_t;

    // One buffered pixel: 8b x, 7b y, 3b colour = 18 bits.
    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        colour_t    colour;
    } pix_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/vga_pixel_writer_if.sv
// Purpose: bundles the plotter pixel stream, clear command and frame-buffer write port.
// Latency: n/a (wiring only).
// Backpressure: oReady throttles iPlot; iMemReady stalls oWren/oAddr/oData.
// Ports: i* are driven by the master (plotter/memory side), o* by the slave (pixel writer).
interface vga_pixel_writer_if #(
    parameter int ADDR_WIDTH = 15
);
    import vga_pkg::*;

    logic [7:0]            iX;
    logic [6:0]            iY;
    colour_t               iColour;
    logic                  iPlot;
    logic                  iClear;
    colour_t               iClearColour;
    logic                  iMemReady;
    logic                  oReady;
    logic [ADDR_WIDTH-1:0] oAddr;
    colour_t               oData;
    logic                  oWren;
    logic                  oBusy;
    logic                  oOverflow;
    logic [7:0]            oClipCount;

    modport master (
        output iX, iY, iColour, iPlot, iClear, iClearColour, iMemReady,
        input  oReady, oAddr, oData, oWren, oBusy, oOverflow, oClipCount
    );

    modport slave (
        input  iX, iY, iColour, iPlot, iClear, iClearColour, iMemReady,
        output oReady, oAddr, oData, oWren, oBusy, oOverflow, oClipCount
    );

endinterface

// File: rtl/pixel_fifo.sv
// Purpose: generic synchronous FIFO (power-of-2 depth) with occupancy count.
// Latency: a push is visible at pop_dat / !empty after one clock edge.
// Backpressure: push ignored while full, pop ignored while empty; caller watches full/empty.
// Ports: clock, resetn (async active-low), push/push_dat, pop/pop_dat, full, empty, count.
module pixel_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage needs no reset; occupancy is tracked by count alone.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/vga_pixel_writer.sv
// Purpose: clip plotter pixels, buffer them, write them to the frame buffer; full-screen clear.
// Latency: pixel pushed into an idle writer appears on oWren/oAddr one edge later.
// Backpressure: oReady (registered !full) gates iPlot; oWren/oAddr/oData hold until iMemReady.
// Ports: iClock, iResetn plain; pixel stream, clear command and write port via bus (slave).
module vga_pixel_writer
    import vga_pkg::*;
#(
    parameter int X_SCREEN_PIXELS = X_SCREEN,
    parameter int Y_SCREEN_PIXELS = Y_SCREEN,
    parameter int FIFO_DEPTH      = FIFO_DEPTH_D,
    parameter int ADDR_WIDTH      = ADDR_W
) (
    input  logic              iClock,
    input  logic              iResetn,
    vga_pixel_writer_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(X_SCREEN_PIXELS * Y_SCREEN_PIXELS - 1);

    pix_t                  fifo_in;
    pix_t                  fifo_out;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         fifo_count_nxt;

    logic                  in_bounds;
    logic                  push;
    logic                  pop;
    logic                  ready_q;
    logic                  overflow_q;
    logic [7:0]            clip_q;

    logic                  wren_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    colour_t               data_q;
    logic [ADDR_WIDTH-1:0] pix_addr;

    logic                  clr_d_q;
    logic                  clr_pend_q;
    colour_t               clr_col_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic                  clr_rise;
    logic                  clr_req;

    state_t                state_q;
    state_t                state_nxt;
    logic                  out_free;
    logic                  xfer_done;
    logic                  load_clr;
    logic                  clr_step;
    logic                  clr_end;

    // ---------------- input side: clip, push, flags ----------------
    assign in_bounds = (bus.iX < 8'(X_SCREEN_PIXELS)) && (bus.iY < 7'(Y_SCREEN_PIXELS));
    assign push      = bus.iPlot && in_bounds && ready_q;

    assign fifo_in.x      = bus.iX;
    assign fifo_in.y      = bus.iY;
    assign fifo_in.colour = bus.iColour;

    // oReady must already reflect the occupancy left by this edge, so it is
    // registered from the next-state count rather than from the current full flag.
    assign fifo_count_nxt = fifo_count + CW'(push) - CW'(pop);

    pixel_fifo #(
        .WIDTH ($bits(pix_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (iClock),
        .resetn   (iResetn),
        .push     (push),
        .push_dat (fifo_in),
        .pop      (pop),
        .pop_dat  (fifo_out),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // y*160 + x as two shifts and adds.
    assign pix_addr = (ADDR_WIDTH'(fifo_out.y) << 7) + (ADDR_WIDTH'(fifo_out.y) << 5)
                    + ADDR_WIDTH'(fifo_out.x);

    // ---------------- control FSM ----------------
    assign out_free  = !wren_q || bus.iMemReady;
    assign xfer_done = wren_q && bus.iMemReady;
    assign clr_rise  = bus.iClear && !clr_d_q;
    assign clr_req   = clr_pend_q || clr_rise;

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) state_q <= S_IDLE;
        else          state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        pop       = 1'b0;
        load_clr  = 1'b0;
        clr_step  = 1'b0;
        clr_end   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_req && out_free) begin
                    load_clr  = 1'b1;
                    state_nxt = S_CLEAR;
                end else if (!fifo_empty && out_free) begin
                    pop       = 1'b1;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                // A pending clear blocks further pops until the in-flight write retires.
                if (clr_req && out_free) begin
                    load_clr  = 1'b1;
                    state_nxt = S_CLEAR;
                end else if (out_free) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_nxt = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (xfer_done) begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        clr_end   = 1'b1;
                        state_nxt = fifo_empty ? S_IDLE : S_WRITE;
                    end else begin
                        clr_step  = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
            clip_q     <= '0;
            clr_d_q    <= 1'b0;
            clr_pend_q <= 1'b0;
            clr_col_q  <= '0;
            clr_cnt_q  <= '0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            ready_q <= (fifo_count_nxt != CW'(FIFO_DEPTH));
            clr_d_q <= bus.iClear;

            if (bus.iPlot && !in_bounds && (clip_q != 8'hFF)) clip_q <= clip_q + 8'd1;
            if (bus.iPlot && in_bounds && !ready_q)           overflow_q <= 1'b1;

            // Remember a clear that arrives while a write is still stalled; a rise
            // during an active clear is dropped.
            if (load_clr) begin
                clr_pend_q <= 1'b0;
            end else if (clr_rise && (state_q != S_CLEAR) && !clr_pend_q) begin
                clr_pend_q <= 1'b1;
                clr_col_q  <= bus.iClearColour;
            end

            if (load_clr) begin
                wren_q    <= 1'b1;
                addr_q    <= '0;
                clr_cnt_q <= '0;
                data_q    <= clr_pend_q ? clr_col_q : bus.iClearColour;
            end else if (clr_step) begin
                addr_q    <= clr_cnt_q + ADDR_WIDTH'(1);
                clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
            end else if (clr_end) begin
                wren_q    <= 1'b0;
            end else if (pop) begin
                wren_q    <= 1'b1;
                addr_q    <= pix_addr;
                data_q    <= fifo_out.colour;
            end else if (xfer_done) begin
                wren_q    <= 1'b0;
            end
        end
    end

    assign bus.oReady     = ready_q;
    assign bus.oAddr      = addr_q;
    assign bus.oData      = data_q;
    assign bus.oWren      = wren_q;
    assign bus.oOverflow  = overflow_q;
    assign bus.oClipCount = clip_q;
    assign bus.oBusy      = !fifo_empty || wren_q || (state_q == S_CLEAR) || clr_pend_q;

    // fifo_full is implied by fifo_count; kept for visibility on the waveform.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_vga_pixel_writer.sv
// Purpose: self-checking bench for vga_pixel_writer (directed cases plus randomized traffic).
// Latency: n/a.
// Backpressure: drives iMemReady low/random to exercise stalls and FIFO fill.
module tb_vga_pixel_writer;
    import vga_pkg::*;

    logic iClock = 1'b0;
    logic iResetn;
    always #5 iClock = ~iClock;

    vga_pixel_writer_if #(.ADDR_WIDTH(15)) bus ();

    vga_pixel_writer #(
        .X_SCREEN_PIXELS (160),
        .Y_SCREEN_PIXELS (120),
        .FIFO_DEPTH      (8),
        .ADDR_WIDTH      (15)
    ) dut (
        .iClock  (iClock),
        .iResetn (iResetn),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;
    wr_t wr_q[$];

    always @(posedge iClock) cyc <= cyc + 1;

    // A write is taken at the next rising edge when oWren and iMemReady are both high.
    always @(negedge iClock) begin
        if (bus.oWren && bus.iMemReady)
            wr_q.push_back('{addr: int'(bus.oAddr), data: int'(bus.oData), cyc: cyc});
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic drive_pix(input int x, input int y, input int c);
        bus.iPlot   = 1'b1;
        bus.iX      = 8'(x);
        bus.iY      = 7'(y);
        bus.iColour = 3'(c);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xs[10];
        int ys[10];
        int cs[10];
        int exp_q[$];
        int bad;
        int pending;
        int x, y, c;

        iResetn          = 1'b0;
        bus.iX           = '0;
        bus.iY           = '0;
        bus.iColour      = '0;
        bus.iPlot        = 1'b0;
        bus.iClear       = 1'b0;
        bus.iClearColour = '0;
        bus.iMemReady    = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) step();
        check("rst_wren",     int'(bus.oWren), 0);
        check("rst_ready",    int'(bus.oReady), 0);
        check("rst_busy",     int'(bus.oBusy), 0);
        check("rst_overflow", int'(bus.oOverflow), 0);
        check("rst_clip",     int'(bus.oClipCount), 0);
        check("rst_addr",     int'(bus.oAddr), 0);
        iResetn = 1'b1;
        repeat (3) step();
        check("ready_after_rst", int'(bus.oReady), 1);

        // ---------------- single pixel ----------------
        wr_q.delete();
        drive_pix(5, 2, 5);
        step();                       // pushed at this edge
        bus.iPlot = 1'b0;
        check("single_lat_early", int'(bus.oWren), 0);
        step();                       // one edge later the write is presented
        check("single_wren", int'(bus.oWren), 1);
        check("single_addr", int'(bus.oAddr), 5 + 2 * 160);
        check("single_data", int'(bus.oData), 5);
        step();
        check("single_wren_off", int'(bus.oWren), 0);
        check("single_busy",     int'(bus.oBusy), 0);
        check("single_nwrites",  wr_q.size(), 1);

        // ---------------- corner pixels back to back ----------------
        wr_q.delete();
        drive_pix(0, 0, 2);
        step();
        drive_pix(159, 119, 6);
        step();
        bus.iPlot = 1'b0;
        repeat (5) step();
        check("corner_nwrites", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            check("corner0_addr", wr_q[0].addr, 0);
            check("corner1_addr", wr_q[1].addr, 19199);
            check("corner1_data", wr_q[1].data, 6);
            check("corner_consec", wr_q[1].cyc - wr_q[0].cyc, 1);
        end

        // ---------------- clipping ----------------
        wr_q.delete();
        drive_pix(160, 0, 1);   step();
        drive_pix(0, 120, 1);   step();
        drive_pix(255, 127, 1); step();
        bus.iPlot = 1'b0;
        repeat (4) step();
        check("clip_count3",   int'(bus.oClipCount), 3);
        check("clip_overflow", int'(bus.oOverflow), 0);
        check("clip_nwrites",  wr_q.size(), 0);
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) drive_pix($urandom_range(160, 255), $urandom_range(0, 127), 1);
            else            drive_pix($urandom_range(0, 255), $urandom_range(120, 127), 1);
            step();
        end
        bus.iPlot = 1'b0;
        step();
        check("clip_saturate", int'(bus.oClipCount), 255);
        check("clip_nwrites2", wr_q.size(), 0);

        // ---------------- backpressure / overflow ----------------
        wr_q.delete();
        bus.iMemReady = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            xs[i] = $urandom_range(0, 159);
            ys[i] = $urandom_range(0, 119);
            cs[i] = $urandom_range(0, 7);
            drive_pix(xs[i], ys[i], cs[i]);
            step();
            if (i >= 1 && (!bus.oWren || int'(bus.oAddr) != ys[0] * 160 + xs[0])) bad++;
        end
        bus.iPlot = 1'b0;
        repeat (3) step();
        check("bp_hold_stable", bad, 0);
        check("bp_ready",       int'(bus.oReady), 0);
        check("bp_overflow",    int'(bus.oOverflow), 1);
        check("bp_wren",        int'(bus.oWren), 1);
        check("bp_addr",        int'(bus.oAddr), ys[0] * 160 + xs[0]);
        bus.iMemReady = 1'b1;
        repeat (15) step();
        check("bp_nwrites", wr_q.size(), 9);
        bad = 0;
        for (int i = 0; i < 9 && i < wr_q.size(); i++)
            if (wr_q[i].addr != ys[i] * 160 + xs[i] || wr_q[i].data != cs[i]) bad++;
        check("bp_order", bad, 0);
        check("bp_busy",  int'(bus.oBusy), 0);

        // ---------------- randomized traffic vs reference queue ----------------
        wr_q.delete();
        exp_q.delete();
        for (int k = 0; k < 400; k++) begin
            bus.iMemReady = ($urandom_range(0, 3) != 0);
            pending = exp_q.size() - wr_q.size();
            if (pending < 5 && $urandom_range(0, 1) == 1) begin
                x = $urandom_range(0, 199);
                y = $urandom_range(0, 127);
                c = $urandom_range(0, 7);
                drive_pix(x, y, c);
                if (x < 160 && y < 120) exp_q.push_back((y * 160 + x) * 8 + c);
            end else begin
                bus.iPlot = 1'b0;
            end
            step();
        end
        bus.iPlot     = 1'b0;
        bus.iMemReady = 1'b1;
        repeat (20) step();
        check("rand_nwrites", wr_q.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            if (wr_q[i].addr * 8 + wr_q[i].data != exp_q[i]) bad++;
        check("rand_order", bad, 0);
        check("rand_clip",  int'(bus.oClipCount), 255);
        check("rand_busy",  int'(bus.oBusy), 0);

        // ---------------- full-screen clear ----------------
        wr_q.delete();
        bus.iClearColour = 3'd1;
        bus.iClear       = 1'b1;
        step();
        bus.iClear = 1'b0;
        for (int k = 0; k < 25000 && wr_q.size() < 19201; k++) begin
            if (k == 1000) drive_pix(10, 10, 6);
            if (k == 1001) bus.iPlot = 1'b0;
            if (k == 2000) begin
                bus.iClear       = 1'b1;     // second rise mid-clear must be ignored
                bus.iClearColour = 3'd7;
            end
            if (k == 2001) bus.iClear = 1'b0;
            step();
        end
        repeat (50) step();
        check("clr_nwrites", wr_q.size(), 19201);
        bad = 0;
        for (int i = 0; i < 19200 && i < wr_q.size(); i++) begin
            if (wr_q[i].addr != i || wr_q[i].data != 1) bad++;
            if (i > 0 && wr_q[i].cyc != wr_q[i-1].cyc + 1) bad++;
        end
        check("clr_sequence", bad, 0);
        if (wr_q.size() > 19200) begin
            check("clr_tail_addr", wr_q[19200].addr, 1610);
            check("clr_tail_data", wr_q[19200].data, 6);
        end
        check("clr_busy", int'(bus.oBusy), 0);

        // ---------------- reset in the middle of a clear ----------------
        wr_q.delete();
        bus.iClearColour = 3'd3;
        bus.iClear       = 1'b1;
        step();
        bus.iClear = 1'b0;
        for (int k = 0; k < 2000 && wr_q.size() < 500; k++) step();
        check("rc_reached", int'(wr_q.size() >= 500), 1);
        check("rc_wren_pre", int'(bus.oWren), 1);
        iResetn = 1'b0;
        #1;
        check("rc_wren",     int'(bus.oWren), 0);
        check("rc_busy",     int'(bus.oBusy), 0);
        check("rc_overflow", int'(bus.oOverflow), 0);
        check("rc_clip",     int'(bus.oClipCount), 0);
        repeat (3) step();
        iResetn = 1'b1;
        wr_q.delete();
        repeat (100) step();
        check("rc_nwrites", wr_q.size(), 0);
        check("rc_ready",   int'(bus.oReady), 1);
        check("rc_busy2",   int'(bus.oBusy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_pixel_writer.md
Name: vga_pixel_writer

Overview:
- Downstream stage of the box plotter; consumes its per-pixel stream (X, Y, colour, plot strobe).
- Clips off-screen pixels and buffers accepted pixels in a small FIFO.
- Converts each accepted pixel to a linear frame-buffer address and writes it to video memory over a valid/ready write handshake.
- Also provides a full-screen clear command that fills every pixel with one colour.

Parameters:
X_SCREEN_PIXELS, 160, horizontal resolution; x values 0..159 are legal
Y_SCREEN_PIXELS, 120, vertical resolution; y values 0..119 are legal
FIFO_DEPTH, 8, pixel FIFO entries; must be a power of 2, minimum 2
ADDR_WIDTH, 15, frame-buffer address width; must satisfy 2^ADDR_WIDTH >= 19200

Ports:
iClock  in  1  system clock, all state on rising edge
iResetn  in  1  asynchronous active-low reset
iX  in  8  pixel x coordinate from plotter
iY  in  7  pixel y coordinate from plotter
iColour  in  3  pixel colour
iPlot  in  1  pixel valid strobe, one pixel per cycle while high
iClear  in  1  clear-screen request, sampled level, acted on once per rising edge of request
iClearColour  in  3  fill colour, captured when clear is accepted
iMemReady  in  1  memory accepts write this cycle
oReady  in/out: out  1  FIFO not full
oAddr  out  ADDR_WIDTH  frame-buffer write address
oData  out  3  write colour
oWren  out  1  write valid
oBusy  out  1  FIFO non-empty, write pending, or clear in progress
oOverflow  out  1  sticky: pixel lost because FIFO full
oClipCount  out  8  saturating count of out-of-bounds pixels discarded

Behaviour:
- Reset (async, iResetn=0):
  - All outputs 0; FIFO empty; state S_IDLE; clear counter 0.
  - Reset mid-clear or mid-write abandons the operation with no further writes.
- Clipping: pixel with iX>=160 or iY>=120 is never pushed; oClipCount+1, saturating at 255. Clipping has priority over overflow.
- Push: iPlot=1, pixel in bounds, oReady=1 at edge -> entry stored. oReady is registered !full from the prior cycle; there is no same-cycle pop bypass.
- Overflow: iPlot=1, pixel in bounds, oReady=0 -> pixel dropped; oOverflow set, cleared only by reset.
- Output register: holds one pixel beyond the FIFO, so total buffering is FIFO_DEPTH+1.
- Address: oAddr = iY*160 + iX, computed as (y<<7)+(y<<5)+x in ADDR_WIDTH bits. (159,119) -> 19199.
- Write handshake:
  - oWren/oAddr/oData are registered and must stay stable while oWren=1 and iMemReady=0.
  - A transfer completes at an edge where oWren=1 and iMemReady=1.
  - The same edge may load the next pixel, giving one write per cycle sustained.
- Latency: pixel pushed at edge N into an empty FIFO with an idle output stage -> oWren=1 with its address after edge N+1.
- FSM states and transitions:
  - S_IDLE -> S_WRITE when FIFO non-empty.
  - S_WRITE -> S_IDLE when FIFO is empty and the last transfer completes.
  - S_IDLE or S_WRITE -> S_CLEAR on a rising edge of iClear, after the current in-flight transfer completes. iClearColour is captured at acceptance.
  - S_CLEAR drives addresses 0..19199 in order, advancing on each completed transfer. After 19199 completes -> S_WRITE if FIFO non-empty, else S_IDLE.
- During S_CLEAR: FIFO keeps accepting pixels (they drain after the clear). A further iClear rising edge is ignored.
- Pixel order: FIFO pixels are written strictly in arrival order.
- Counter width: the clear counter is ADDR_WIDTH bits; it must not wrap past 19199.

Decomposition:
- Shared package vga_pkg:
  - Screen size constants (160, 120, 19200).
  - Colour width (3).
  - Address width.
  - FSM state encodings S_IDLE, S_WRITE, S_CLEAR.
- One natural sub-module: pixel_fifo, a synchronous FIFO.
  - Parameterised width (18: x, y, colour) and depth.
  - Ports: push, pop, full, empty.
  - Async active-low reset.

Test Plan:
- Single pixel (x=5, y=2, colour=3'b101), iMemReady=1 -> exactly one write: oAddr=325, oData=5, oWren high for one cycle; then oBusy=0.
- Corner pixels (0,0) and (159,119) pushed on back-to-back cycles, iMemReady=1 -> writes at addresses 0 then 19199 on consecutive cycles, in order.
- Clipping: pixels (160,0), (0,120), (255,127) -> no writes, oClipCount=3, oOverflow=0. Then 300 clipped pixels -> oClipCount=255.
- Backpressure: iMemReady=0, push 10 in-bounds pixels on consecutive cycles:
  - First pixel held in the output register with stable oAddr.
  - 8 pixels in the FIFO; oReady=0.
  - 10th pixel dropped; oOverflow=1.
  - Release iMemReady -> exactly 9 writes in push order.
- Clear: iClear pulse with iClearColour=3'b001, iMemReady=1 -> 19200 consecutive writes, addresses 0..19199, oData=1. A pixel (10,10) pushed mid-clear is written after address 19199, at address 1610.
- Reset mid-clear: assert iResetn=0 at clear address ~500 -> oWren=0 immediately; oBusy=0, oOverflow=0, oClipCount=0; no further writes after reset is released.
